// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle for alu_seq.
// master = issuing side (decode / testbench), slave = the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             out_jump;
  logic             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_jump, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_jump, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with carry/zero/jump flags.
// Rotate-left is iterative (one bit per cycle) unless ALU_SEQ_FAST_ROT_EN is
// defined, in which case a single-cycle barrel rotate is built instead.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpXor  = 3'd1;
  localparam logic [2:0] OpAnd  = 3'd2;
  localparam logic [2:0] OpRsl  = 3'd3;
  localparam logic [2:0] OpMov  = 3'd4;
  localparam logic [2:0] OpLd   = 3'd5;
  localparam logic [2:0] OpSt   = 3'd6;
  localparam logic [2:0] OpBlqz = 3'd7;

  localparam logic [1:0] StIdle = 2'd0;
`ifndef ALU_SEQ_FAST_ROT_EN
  localparam logic [1:0] StRot  = 2'd1;
`endif
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             jump_q, jump_d;
  logic             valid_q, valid_d;
`ifndef ALU_SEQ_FAST_ROT_EN
  logic [SHW-1:0]   cnt_q, cnt_d;
`endif

  logic             accept;
  logic [SHW-1:0]   k;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;
  logic             op_jump;

  assign bus.in_ready = (state_q == StIdle) | ((state_q == StHold) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign k            = bus.in_b[SHW-1:0];
  assign sum          = {1'b0, bus.in_a} + {1'b0, bus.in_b};

  // Single-cycle result of the presented op (rotate handled separately when iterative).
  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    op_jump  = 1'b0;
    case (bus.in_op)
      OpAdd: begin
        op_res   = sum[WIDTH-1:0];
        op_carry = sum[WIDTH];
      end
      OpXor:  op_res = bus.in_a ^ bus.in_b;
      OpAnd:  op_res = bus.in_a & bus.in_b;
`ifdef ALU_SEQ_FAST_ROT_EN
      // A shift by WIDTH yields zero, so k == 0 falls out naturally.
      OpRsl:  op_res = (bus.in_a << k) | (bus.in_a >> (WIDTH - 32'(k)));
`else
      // Seed value; the ROT state does the actual rotation.
      OpRsl:  op_res = bus.in_a;
`endif
      OpMov:  op_res = bus.in_b;
      OpLd:   op_res = bus.in_a;
      OpSt:   op_res = bus.in_a;
      OpBlqz: op_jump = (bus.in_a <= bus.in_b);
      default: ;
    endcase
  end

  // Next-state: accept / rotate / release of the result registers.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    jump_d   = jump_q;
    valid_d  = valid_q;
`ifndef ALU_SEQ_FAST_ROT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
`ifndef ALU_SEQ_FAST_ROT_EN
      StRot: begin
        result_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
        cnt_d    = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = StHold;
          valid_d = 1'b1;
          zero_d  = (result_d == '0);
        end
      end
`endif
      default: begin
        // Idle or holding: the consumer may drain and a new op may enter together.
        if ((state_q == StHold) && bus.out_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
        if (accept) begin
          result_d = op_res;
          carry_d  = op_carry;
          jump_d   = op_jump;
          zero_d   = (op_res == '0);
          state_d  = StHold;
          valid_d  = 1'b1;
`ifndef ALU_SEQ_FAST_ROT_EN
          if ((bus.in_op == OpRsl) && (k != '0)) begin
            state_d = StRot;
            valid_d = 1'b0;
            zero_d  = 1'b0;
            cnt_d   = k;
          end
`endif
        end
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      jump_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifndef ALU_SEQ_FAST_ROT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      jump_q   <= jump_d;
      valid_q  <= valid_d;
`ifndef ALU_SEQ_FAST_ROT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_jump   = jump_q;
  assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, scoreboarded bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
`ifdef ALU_SEQ_FAST_ROT_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(16)) b16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));

  typedef struct packed {
    logic [15:0] res;
    logic        carry;
    logic        zero;
    logic        jump;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        busy;
    logic [15:0] res;
    logic        carry;
    logic        zero;
    logic        jump;
  } obs_t;

  exp_t q8[$];
  exp_t q16[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model, written from the op table with plain integer arithmetic.
  function automatic exp_t model(input int w, input logic [2:0] op,
                                 input logic [15:0] a_in, input logic [15:0] b_in);
    logic [31:0] mask, a, b, s;
    int          k;
    exp_t        e;
    mask = (32'd1 << w) - 32'd1;
    a    = {16'd0, a_in} & mask;
    b    = {16'd0, b_in} & mask;
    e    = '0;
    case (op)
      3'd0: begin
        s       = a + b;
        e.res   = 16'(s & mask);
        e.carry = s[w];
      end
      3'd1: e.res = 16'(a ^ b);
      3'd2: e.res = 16'(a & b);
      3'd3: begin
        k     = int'(b) % w;
        s     = ((a << k) | (a >> (w - k))) & mask;
        e.res = 16'(s);
      end
      3'd4: e.res = 16'(b);
      3'd7: e.jump = (a <= b);
      default: e.res = 16'(a);
    endcase
    e.zero = (e.res == 16'd0);
    return e;
  endfunction

  function automatic obs_t observe(input int w);
    obs_t o;
    if (w == 8) begin
      o.valid = b8.out_valid;
      o.ready = b8.in_ready;
      o.busy  = b8.busy;
      o.res   = {8'd0, b8.out_result};
      o.carry = b8.out_carry;
      o.zero  = b8.out_zero;
      o.jump  = b8.out_jump;
    end else begin
      o.valid = b16.out_valid;
      o.ready = b16.in_ready;
      o.busy  = b16.busy;
      o.res   = b16.out_result;
      o.carry = b16.out_carry;
      o.zero  = b16.out_zero;
      o.jump  = b16.out_jump;
    end
    return o;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      b8.in_valid = v;
      b8.in_op    = op;
      b8.in_a     = a[7:0];
      b8.in_b     = b[7:0];
    end else begin
      b16.in_valid = v;
      b16.in_op    = op;
      b16.in_a     = a;
      b16.in_b     = b;
    end
  endtask

  // Present a request, wait (bounded) for acceptance; returns 1 ns after the accepting edge.
  task automatic issue(input int w, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit push);
    int   n;
    obs_t o;
    n = 0;
    set_in(w, 1'b1, op, a, b);
    #1;
    o = observe(w);
    while (!o.ready && n < 20) begin
      @(posedge clk);
      #2;
      o = observe(w);
      n++;
    end
    if (n >= 20) chk("accept_timeout", o.ready, 1);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, op, a, b);
    if (push) begin
      if (w == 8) q8.push_back(model(8, op, a, b));
      else        q16.push_back(model(16, op, a, b));
    end
  endtask

  // Count cycles (from the first cycle after accept) until out_valid, and stall cycles seen.
  task automatic wait_valid(input int w, output int lat, output int stalls);
    obs_t o;
    lat    = 1;
    stalls = 0;
    o      = observe(w);
    while (!o.valid && lat < 40) begin
      if (!o.ready) stalls++;
      @(posedge clk);
      #1;
      o = observe(w);
      lat++;
    end
  endtask

  // Compare current outputs against the oldest scoreboard entry.
  task automatic check_out(input int w, input string tag);
    obs_t o;
    exp_t e;
    int   sz;
    o  = observe(w);
    sz = (w == 8) ? q8.size() : q16.size();
    chk({tag, "_valid"}, o.valid, 1);
    if (sz == 0) begin
      chk({tag, "_sb"}, 32'(sz), 1);
    end else begin
      e = (w == 8) ? q8.pop_front() : q16.pop_front();
      chk({tag, "_res"},   o.res,   e.res);
      chk({tag, "_carry"}, o.carry, e.carry);
      chk({tag, "_zero"},  o.zero,  e.zero);
      chk({tag, "_jump"},  o.jump,  e.jump);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   lat;
    int   stl;
    int   seen;

    reset = 1'b1;
    set_in(8, 1'b0, 3'd0, 16'd0, 16'd0);
    set_in(16, 1'b0, 3'd0, 16'd0, 16'd0);
    b8.out_ready  = 1'b0;
    b16.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = observe(8);
    chk("rst_valid", o.valid, 0);
    chk("rst_res",   o.res,   0);
    chk("rst_carry", o.carry, 0);
    chk("rst_zero",  o.zero,  0);
    chk("rst_jump",  o.jump,  0);
    chk("rst_busy",  o.busy,  0);
    chk("rst_ready", o.ready, 1);
    o = observe(16);
    chk("rst16_res", o.res, 0);
    reset = 1'b0;

    // ADD with carry out, latency 1.
    b8.out_ready = 1'b1;
    issue(8, 3'd0, 16'h00F0, 16'h0020, 1'b1);
    o = observe(8);
    chk("add_res_direct", o.res, 16'h0010);
    check_out(8, "add");
    @(posedge clk);
    #1;
    o = observe(8);
    chk("add_drop", o.valid, 0);

    // Back-to-back BLQZ, no bubble.
    set_in(8, 1'b1, 3'd7, 16'h0005, 16'h0005);
    #1;
    o = observe(8);
    chk("blqz_ready0", o.ready, 1);
    @(posedge clk);
    #1;
    q8.push_back(model(8, 3'd7, 16'h0005, 16'h0005));
    o = observe(8);
    chk("blqz1_jump_direct", o.jump, 1);
    check_out(8, "blqz1");
    set_in(8, 1'b1, 3'd7, 16'h0006, 16'h0005);
    #1;
    o = observe(8);
    chk("blqz_ready1", o.ready, 1);
    @(posedge clk);
    #1;
    q8.push_back(model(8, 3'd7, 16'h0006, 16'h0005));
    set_in(8, 1'b0, 3'd0, 16'd0, 16'd0);
    o = observe(8);
    chk("blqz2_jump_direct", o.jump, 0);
    check_out(8, "blqz2");
    #1;
    o = observe(8);
    chk("blqz_ready2", o.ready, 1);
    @(posedge clk);
    #1;
    o = observe(8);
    chk("blqz_drop", o.valid, 0);

    // Rotate k=3 (upper bits of b ignored).
    issue(8, 3'd3, 16'h0081, 16'h000B, 1'b1);
    wait_valid(8, lat, stl);
    chk("rsl3_lat",   32'(lat), Fast ? 1 : 4);
    chk("rsl3_stall", 32'(stl), Fast ? 0 : 3);
    o = observe(8);
    chk("rsl3_res_direct", o.res, 16'h000C);
    check_out(8, "rsl3");
    @(posedge clk);
    #1;

    // Rotate k=0 via ignored upper bits: latency 1 in both builds.
    issue(8, 3'd3, 16'h005A, 16'h0008, 1'b1);
    wait_valid(8, lat, stl);
    chk("rsl0_lat", 32'(lat), 1);
    check_out(8, "rsl0");
    @(posedge clk);
    #1;

    // Rotate k=7 (maximum).
    issue(8, 3'd3, 16'h0096, 16'h0007, 1'b1);
    wait_valid(8, lat, stl);
    chk("rsl7_lat", 32'(lat), Fast ? 1 : 8);
    check_out(8, "rsl7");
    @(posedge clk);
    #1;

    // XOR with consumer stalled for 5 cycles.
    b8.out_ready = 1'b0;
    issue(8, 3'd1, 16'h00AA, 16'h00AA, 1'b1);
    check_out(8, "xor");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      o = observe(8);
      chk("xor_hold_valid", o.valid, 1);
      chk("xor_hold_res",   o.res,   0);
      chk("xor_hold_zero",  o.zero,  1);
      chk("xor_hold_ready", o.ready, 0);
    end
    b8.out_ready = 1'b1;
    #1;
    o = observe(8);
    chk("xor_release_ready", o.ready, 1);
    @(posedge clk);
    #1;
    o = observe(8);
    chk("xor_drop_valid", o.valid, 0);
    chk("xor_drop_busy",  o.busy,  0);

    // Reset during the 2nd ROT cycle discards the op.
    issue(8, 3'd3, 16'h0001, 16'h0007, 1'b0);
    @(posedge clk);
    #1;
    o = observe(8);
    chk("rstrot_busy_before", o.busy, Fast ? 0 : 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    o = observe(8);
    chk("rstrot_valid", o.valid, 0);
    chk("rstrot_busy",  o.busy,  0);
    chk("rstrot_ready", o.ready, 1);
    chk("rstrot_res",   o.res,   0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      o = observe(8);
      if (o.valid) seen++;
    end
    chk("rstrot_no_result", 32'(seen), 0);

    // WIDTH=16 cases.
    b16.out_ready = 1'b1;
    issue(16, 3'd0, 16'hFFFF, 16'h0001, 1'b1);
    o = observe(16);
    chk("add16_carry_direct", o.carry, 1);
    chk("add16_zero_direct",  o.zero,  1);
    check_out(16, "add16");
    @(posedge clk);
    #1;
    issue(16, 3'd3, 16'h8001, 16'h0011, 1'b1);
    wait_valid(16, lat, stl);
    chk("rsl16_lat", 32'(lat), Fast ? 1 : 2);
    o = observe(16);
    chk("rsl16_res_direct", o.res, 16'h0003);
    check_out(16, "rsl16");
    @(posedge clk);
    #1;

    chk("sb8_empty",  32'(q8.size()),  0);
    chk("sb16_empty", 32'(q16.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 8-bit combinational ALU.
- Same 3-bit opcode set. Operand width is set by a parameter.
- Results are registered and carry carry/zero/jump flags.
- Rotate-left runs iteratively, one bit per cycle, under a small FSM.
- Sits between decode and writeback/PC logic; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), width of the rotate amount field (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- in_op  in  3  ADD=0, XOR=1, AND=2, RSL=3, MOV=4, LD=5, ST=6, BLQZ=7.
- in_a  in  WIDTH  operand 1.
- in_b  in  WIDTH  operand 2 / rotate amount.
- out_valid  out  1  result registers hold a completed op.
- out_ready  in  1  consumer takes result this cycle.
- out_result  out  WIDTH  registered result.
- out_carry  out  1  carry-out of ADD; 0 for other ops.
- out_zero  out  1  out_result == 0.
- out_jump  out  1  BLQZ taken: in_a <= in_b, unsigned.
- busy  out  1  FSM not in IDLE.

Behaviour:
- FSM states: IDLE, ROT, HOLD.
- Reset (synchronous): state=IDLE; out_valid=0, out_result=0, out_carry=0, out_zero=0, out_jump=0, busy=0, rotate counter=0.
  - Reset mid-ROT or mid-HOLD discards the op; no output handshake occurs.
- Accept condition: in_valid & in_ready.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Back-to-back throughput is one non-rotate op per cycle.
- On accept, by op:
  - ADD: {carry,result} = in_a + in_b, computed at WIDTH+1 bits.
  - XOR: result = in_a ^ in_b.
  - AND: result = in_a & in_b.
  - MOV: result = in_b.
  - LD, ST: result = in_a.
  - BLQZ: result = 0; jump = (in_a <= in_b), unsigned.
  - For all of the above: next state HOLD, out_valid=1 the following cycle. Latency is 1.
- RSL, rotate left by k = in_b[SHW-1:0]; upper bits of in_b are ignored:
  - k==0: result=in_a, go to HOLD, latency 1.
  - k>0: result register loads in_a, counter loads k, state goes to ROT.
  - Each ROT cycle: result = {result[WIDTH-2:0], result[WIDTH-1]}; counter decrements.
  - When counter reaches 0 (after the k-th rotate), go to HOLD.
  - Result equals in_a rotated left k places. out_valid asserts k+1 cycles after accept.
- Flags:
  - out_zero is computed from the final result when entering HOLD.
  - out_carry and out_jump are 0 except for ADD and BLQZ respectively.
  - Flags are held with out_result.
- HOLD:
  - out_valid=1; all outputs stable while out_ready=0.
  - out_ready=1 with no accept: go to IDLE, out_valid=0 next cycle.
  - out_ready=1 with simultaneous accept: the new op's behaviour applies. No bubble for non-rotate ops.
- Outputs are meaningful only while out_valid=1. In IDLE they retain their last values.
- Unknown/illegal opcodes cannot occur; all 8 encodings are defined.
- busy = (state != IDLE).

Optional Feature:
- Macro: ALU_SEQ_FAST_ROT_EN.
- Defined:
  - RSL uses a single-cycle barrel rotate with latency 1 for every k.
  - The ROT state and counter are not built; busy is never 1 due to rotation.
- Undefined: iterative rotate as described above; latency k+1.
- The result value is identical in both builds.

Test Plan:
- WIDTH=8, ADD a=0xF0, b=0x20, out_ready=1 -> one cycle later out_valid=1, result=0x10, carry=1, zero=0.
- BLQZ a=0x05, b=0x05, then a=0x06, b=0x05 back-to-back with out_ready=1:
  - Jump = 1 then 0 on consecutive cycles.
  - in_ready stays 1 throughout; result=0, zero=1.
- RSL a=0x81, b=0x0B (k=3), macro off:
  - in_ready=0 for 3 cycles; out_valid 4 cycles after accept; result=0x0C.
  - With macro on: out_valid after 1 cycle, same result.
- XOR a=0xAA, b=0xAA with out_ready=0 for 5 cycles:
  - out_valid held; result=0x00, zero=1 stable; in_ready=0.
  - Raise out_ready -> out_valid drops next cycle.
- RSL a=0x01, b=0x07, reset asserted during the 2nd ROT cycle:
  - Next cycle state=IDLE, out_valid=0, busy=0, in_ready=1, result=0.
  - No result is produced.
- WIDTH=16, ADD a=0xFFFF, b=0x0001 -> result=0x0000, carry=1, zero=1.
- WIDTH=16, RSL a=0x8001, b=0x0011 (k=1) -> result=0x0003.
